// File: rtl/microsequencer.sv
// Microcode sequencer for the multiplier control unit: uPC, branch evaluation, registered control issue.
// Optional build macro USEQ_CYCLE_COUNT_EN adds the ucycles run-cycle counter output.
//
// state | meaning
// IDLE  | waiting for start after reset, uPC parked at 0
// RUN   | fetching one control word per cycle and issuing its cbits
// HALT  | program finished (halt word or illegal target), done high
module microsequencer #(
  parameter int unsigned AW         = 5,
  parameter int unsigned DW         = 23,
  parameter int unsigned CW         = 15,
  parameter int unsigned DEPTH      = 18,
  parameter int unsigned START_ADDR = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  input  logic [2:0]    status,
  output logic [CW-1:0] ctrl,
  output logic          ctrl_valid,
  output logic          busy,
  output logic          done,
  output logic          illegal
`ifdef USEQ_CYCLE_COUNT_EN
  ,
  output logic [7:0]    ucycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] upc;

  logic [2:0]    cond;
  logic [AW-1:0] target;
  logic [CW-1:0] cbits;
  logic [AW:0]   upc_inc;
  logic [AW:0]   next_pc;
  logic          take;
  logic          bad_cond;
  logic          is_halt;
  logic          out_of_range;

  assign cond   = data[DW-1 -: 3];
  assign target = data[CW+AW-1 : CW];
  assign cbits  = data[CW-1:0];
  assign addr   = upc;
  assign busy   = (state == RUN);
  assign done   = (state == HALT);

  // Increment is one bit wider so a wrap past the top address is caught, not folded to 0.
  assign upc_inc = {1'b0, upc} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    take     = 1'b0;
    bad_cond = 1'b0;
    case (cond)
      3'd0:    take = 1'b1;
      3'd1:    take = status[0];
      3'd2:    take = status[1];
      3'd3:    take = status[2];
      3'd4:    take = 1'b1;
      default: bad_cond = 1'b1;
    endcase
    next_pc      = take ? {1'b0, target} : upc_inc;
    is_halt      = (cond == 3'd4) && (target == upc);
    out_of_range = next_pc > (AW+1)'(DEPTH - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      upc        <= '0;
      ctrl       <= '0;
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
`ifdef USEQ_CYCLE_COUNT_EN
      ucycles    <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          ctrl       <= cbits;
          ctrl_valid <= 1'b1;
`ifdef USEQ_CYCLE_COUNT_EN
          if (ucycles != 8'hff) ucycles <= ucycles + 8'd1;
`endif
          if (bad_cond) illegal <= 1'b1;
          if (is_halt) begin
            state <= HALT;
          end else if (out_of_range) begin
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            upc <= next_pc[AW-1:0];
          end
        end
        default: begin
          // IDLE and HALT both drop the control bus and wait for start.
          ctrl       <= '0;
          ctrl_valid <= 1'b0;
          if (start) begin
            state <= RUN;
            upc   <= AW'(START_ADDR);
`ifdef USEQ_CYCLE_COUNT_EN
            ucycles <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Control-unit front end of the microcoded multiplier.
- Holds the micro-program counter (uPC) and drives the address of the combinational 23-bit × 18-word control ROM; consumes the returned control word.
- Evaluates the word's branch field against datapath status flags to select the next uPC.
- Issues the word's 15 datapath control bits, registered, to the datapath, with a start/done handshake toward the host.

Parameters:
AW, 5, ROM address width
DW, 23, control word width
CW, 15, datapath control field width (DW-8)
DEPTH, 18, number of valid ROM words
START_ADDR, 0, uPC entry point on start

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  host request to run micro-program; level sampled each edge
addr  output  AW  ROM address, combinational from uPC
data  input  DW  ROM word for addr, same cycle
status  input  3  datapath condition flags: status[0], status[1], status[2]
ctrl  output  CW  registered datapath control bits
ctrl_valid  output  1  ctrl holds a live control word this cycle
busy  output  1  high in RUN
done  output  1  high in HALT
illegal  output  1  sticky: reserved cond code or out-of-range target seen

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (`reset`).
- Word fields: cond = data[22:20], target = data[19:15], cbits = data[14:0].
- Next-uPC by cond:
  - 0: target, unconditional.
  - 1: target if status[0], else uPC+1.
  - 2: target if status[1], else uPC+1.
  - 3: target if status[2], else uPC+1.
  - 4: target, unconditional jump. If target == uPC, this is a halt.
  - 5–7: reserved. Next uPC is uPC+1 and illegal is set.
- Status is sampled in the same cycle as the word whose cond is being evaluated.
- States: IDLE, RUN, HALT. busy = (RUN); done = (HALT).
- Reset value (also applied when reset is asserted mid-operation, taking effect on the next edge): state IDLE, uPC 0, ctrl 0, ctrl_valid 0, illegal 0.
- IDLE:
  - addr = uPC = 0; ctrl and ctrl_valid are 0.
  - start=1 → RUN; uPC <= START_ADDR.
- RUN, each cycle:
  - addr = uPC.
  - ctrl <= cbits and ctrl_valid <= 1 (latency 1: word at address A appears on ctrl the cycle after addr = A).
  - uPC <= next-uPC.
  - start is ignored in RUN.
- Halt word (cond 4, target == uPC): its cbits are issued once, then state <= HALT.
- Out-of-range next-uPC (> DEPTH-1, including uPC+1 wrap past 17): set illegal, state <= HALT, uPC held. The current word's cbits are still issued.
- HALT:
  - ctrl <= 0, ctrl_valid <= 0.
  - done stays high until start=1, which restarts RUN at START_ADDR and clears done on that edge.
  - illegal is not cleared by start.
- Simultaneous events: reset wins over start. start asserted on the same edge as entering HALT is not seen until the next edge.
- uPC+1 is computed AW+1 bits wide to detect overflow; 31+1 is never truncated to 0.

Optional Feature:
Macro USEQ_CYCLE_COUNT_EN.
- Defined: adds output ucycles [7:0].
  - Cleared on reset and on each start accepted from IDLE or HALT.
  - Increments once per RUN cycle, saturating at 255.
  - Holds its value in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, start held low: addr=0, ctrl=0, ctrl_valid=0, busy=0, done=0 for 10 cycles.
- Stub ROM words: [0]={0,1,0x0003}, [1]={0,2,0x000C}, [2]={4,2,0x0300}. Pulse start. Required trace:
  - addr 0,1,2.
  - ctrl 0x0003, 0x000C, 0x0300 on the following cycles.
  - done=1 the cycle 0x0300 appears, then ctrl=0 and ctrl_valid=0.
- Conditional branch, word [3]={1,12,0}:
  - status[0]=1 → next addr 12.
  - Repeated with status[0]=0 → next addr 4.
- Repeat for cond 2 using status[1] and cond 3 using status[2].
- Reserved cond 6 at addr 5: illegal=1 and uPC=6. Word {0,31,0}: illegal, HALT, done=1.
- Reset asserted mid-RUN at addr 9: next edge IDLE, addr=0, ctrl_valid=0. A subsequent start re-runs from 0 with identical trace.
- USEQ_CYCLE_COUNT_EN:
  - Three-word program → ucycles=3 in HALT.
  - 300-cycle loop → ucycles=255.
